// File: rtl/mem_ctrl_multiport.sv
`default_nettype none
// ============================================================================
// mem_ctrl_multiport : arbitrates NUM_PORTS requesters onto the 8-bit RAM/IO bus
// Rev 1.0
// ============================================================================
module mem_ctrl_multiport #(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = 0,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic [7:0]                  mem_din,
    output logic [7:0]                  mem_dout,
    output logic [ADDR_W-1:0]           mem_a,
    output logic                        mem_wr,
    input  logic                        io_buffer_full,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [2*NUM_PORTS-1:0]      req_size,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0]     req_wdata,
    input  logic [NUM_PORTS-1:0]        req_flush,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic                        busy
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_IO_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          nbytes_q, nbytes_d;
    logic [2:0]          issue_idx_q, issue_idx_d;
    logic [2:0]          cap_idx_q, cap_idx_d;
    logic                addr_vld_q, addr_vld_d;
    logic                data_vld_q, data_vld_d;
    logic [31:0]         rdata_acc_q, rdata_acc_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;
    logic                stall_q, stall_d;

    logic [NUM_PORTS-1:0] elig;
    logic                 grant_vld;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        cand;
    logic                 sel_wr;
    logic [1:0]           sel_size;
    logic [ADDR_W-1:0]    sel_addr;
    logic [31:0]          sel_wdata;
    logic [2:0]           nxt_idx;
    logic [ADDR_W-1:0]    nxt_addr;

    function automatic logic [2:0] size_to_n(input logic [1:0] s);
        return (s == 2'd0) ? 3'd1 : ((s == 2'd1) ? 3'd2 : 3'd4);
    endfunction

    function automatic logic io_region(input logic [ADDR_W-1:0] a);
        return (a[17:16] == 2'b11);
    endfunction

    // Round-robin scans pointer+NUM_PORTS down to pointer+1 so the last hit is the nearest.
    always_comb begin
        elig      = req_valid & ~req_flush;
        grant_vld = |elig;
        grant_idx = '0;
        cand      = '0;
        if (ARB_MODE == 0) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (elig[PW'(k)]) grant_idx = PW'(k);
            end
        end else begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                cand = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
                if (elig[cand]) grant_idx = cand;
            end
        end
    end

    assign sel_wr    = req_wr[grant_idx];
    assign sel_size  = req_size[2*grant_idx +: 2];
    assign sel_addr  = req_addr[ADDR_W*grant_idx +: ADDR_W];
    assign sel_wdata = req_wdata[32*grant_idx +: 32];
    assign stall_d   = ~rdy_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= PW'(NUM_PORTS - 1);
            base_q      <= '0;
            wdata_q     <= '0;
            nbytes_q    <= '0;
            issue_idx_q <= '0;
            cap_idx_q   <= '0;
            addr_vld_q  <= 1'b0;
            data_vld_q  <= 1'b0;
            rdata_acc_q <= '0;
            rsp_rdata_q <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            stall_q <= stall_d;
            if (rdy_in) begin
                state_q     <= state_d;
                owner_q     <= owner_d;
                rr_ptr_q    <= rr_ptr_d;
                base_q      <= base_d;
                wdata_q     <= wdata_d;
                nbytes_q    <= nbytes_d;
                issue_idx_q <= issue_idx_d;
                cap_idx_q   <= cap_idx_d;
                addr_vld_q  <= addr_vld_d;
                data_vld_q  <= data_vld_d;
                rdata_acc_q <= rdata_acc_d;
                rsp_rdata_q <= rsp_rdata_d;
                mem_a_q     <= mem_a_d;
                mem_dout_q  <= mem_dout_d;
                mem_wr_q    <= mem_wr_d;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        nbytes_d    = nbytes_q;
        issue_idx_d = issue_idx_q;
        cap_idx_d   = cap_idx_q;
        addr_vld_d  = addr_vld_q;
        data_vld_d  = data_vld_q;
        rdata_acc_d = rdata_acc_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        nxt_idx     = issue_idx_q + 3'd1;
        nxt_addr    = base_q + ADDR_W'(nxt_idx);
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d     = grant_idx;
                    if (ARB_MODE != 0) rr_ptr_d = grant_idx;
                    base_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    nbytes_d    = size_to_n(sel_size);
                    issue_idx_d = 3'd0;
                    cap_idx_d   = 3'd0;
                    data_vld_d  = 1'b0;
                    addr_vld_d  = 1'b0;
                    rdata_acc_d = '0;
                    mem_a_d     = sel_addr;
                    mem_dout_d  = sel_wdata[7:0];
                    if (!sel_wr) begin
                        state_d    = S_READ;
                        addr_vld_d = 1'b1;
                    end else if (io_region(sel_addr) && io_buffer_full) begin
                        state_d    = S_IO_WAIT;
                    end else begin
                        state_d    = S_WRITE;
                        mem_wr_d   = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (req_flush[owner_q]) begin
                    state_d    = S_IDLE;
                    addr_vld_d = 1'b0;
                    data_vld_d = 1'b0;
                end else if (stall_q) begin
                    // mem_din is stale after a pause: restart from the first missing byte.
                    data_vld_d  = 1'b0;
                    addr_vld_d  = 1'b1;
                    issue_idx_d = cap_idx_q;
                    mem_a_d     = base_q + ADDR_W'(cap_idx_q);
                end else begin
                    if (data_vld_q) begin
                        rdata_acc_d[8*cap_idx_q[1:0] +: 8] = mem_din;
                        cap_idx_d = cap_idx_q + 3'd1;
                        if (cap_idx_q == nbytes_q - 3'd1) begin
                            state_d     = S_DONE;
                            rsp_rdata_d = rdata_acc_d;
                        end
                    end
                    data_vld_d = addr_vld_q;
                    if (addr_vld_q && (nxt_idx < nbytes_q)) begin
                        issue_idx_d = nxt_idx;
                        mem_a_d     = nxt_addr;
                        addr_vld_d  = 1'b1;
                    end else begin
                        addr_vld_d  = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                if (nxt_idx < nbytes_q) begin
                    issue_idx_d = nxt_idx;
                    mem_a_d     = nxt_addr;
                    mem_dout_d  = wdata_q[8*nxt_idx[1:0] +: 8];
                    if (io_region(nxt_addr) && io_buffer_full) state_d = S_IO_WAIT;
                    else mem_wr_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_d  = S_WRITE;
                    mem_wr_d = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_a     = mem_a_q;
        mem_dout  = mem_dout_q;
        mem_wr    = mem_wr_q & rdy_in;
        rsp_rdata = rsp_rdata_q;
        busy      = (state_q != S_IDLE);
        rsp_valid = '0;
        if ((state_q == S_DONE) && rdy_in) rsp_valid[owner_q] = 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_multiport.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl_multiport : directed self-checking bench for mem_ctrl_multiport
// Rev 1.0
// ============================================================================
module tb_mem_ctrl_multiport;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        io_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [1:0]  req_valid, req_wr, req_flush;
    logic [3:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;

    logic [7:0]  rr_mem_din;
    logic [7:0]  rr_mem_dout;
    logic [31:0] rr_mem_a;
    logic        rr_mem_wr;
    logic [1:0]  rr_req_valid, rr_req_wr, rr_req_flush;
    logic [3:0]  rr_req_size;
    logic [63:0] rr_req_addr, rr_req_wdata;
    logic [1:0]  rr_rsp_valid;
    logic [31:0] rr_rsp_rdata;
    logic        rr_busy;

    logic [7:0]  ram [0:4095];
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    mem_ctrl_multiport #(.NUM_PORTS(2), .ARB_MODE(0), .ADDR_W(32)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_full), .req_valid(req_valid), .req_wr(req_wr),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_flush(req_flush), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy)
    );

    mem_ctrl_multiport #(.NUM_PORTS(2), .ARB_MODE(1), .ADDR_W(32)) dut_rr (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .mem_din(rr_mem_din),
        .mem_dout(rr_mem_dout), .mem_a(rr_mem_a), .mem_wr(rr_mem_wr),
        .io_buffer_full(io_full), .req_valid(rr_req_valid), .req_wr(rr_req_wr),
        .req_size(rr_req_size), .req_addr(rr_req_addr), .req_wdata(rr_req_wdata),
        .req_flush(rr_req_flush), .rsp_valid(rr_rsp_valid), .rsp_rdata(rr_rsp_rdata),
        .busy(rr_busy)
    );

    // Byte RAM with one-cycle read latency; preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            ram[12'h100] <= 8'h11;
            ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33;
            ram[12'h103] <= 8'h44;
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic p, input logic v, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid[p]          = v;
        req_wr[p]             = wr;
        req_size[2*p +: 2]    = sz;
        req_addr[32*p +: 32]  = a;
        req_wdata[32*p +: 32] = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr_cnt, rsp_cnt, got;
        logic [31:0] wr_a;
        logic [7:0]  wr_d, rr_first_d;
        logic [1:0]  rsp_seen;
        logic [1:0]  order [0:3];

        rst_n = 1'b0; rdy = 1'b1; io_full = 1'b0;
        req_valid = '0; req_wr = '0; req_flush = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        rr_req_valid = '0; rr_req_wr = '0; rr_req_flush = '0; rr_req_size = '0;
        rr_req_addr = '0; rr_req_wdata = '0; rr_mem_din = 8'h00;
        wr_a = '0; wr_d = '0; rr_first_d = '0; rsp_seen = '0;
        for (int i = 0; i < 4; i++) order[i] = '0;

        tick(); tick();
        check_eq("reset_mem_a", mem_a, 32'h0);
        check_eq("reset_mem_wr", 32'(mem_wr), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_rsp", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        // Port 0, 4-byte read at 0x100.
        set_req(1'b0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        tick(); check_eq("rd4_a0", mem_a, 32'h100); check_eq("rd4_busy", 32'(busy), 32'h1);
        tick(); check_eq("rd4_a1", mem_a, 32'h101);
        tick(); check_eq("rd4_a2", mem_a, 32'h102);
        tick(); check_eq("rd4_a3", mem_a, 32'h103);
        tick(); check_eq("rd4_no_rsp_t5", 32'(rsp_valid), 32'h0);
        tick(); check_eq("rd4_rsp_t6", 32'(rsp_valid), 32'h1);
        check_eq("rd4_rdata", rsp_rdata, 32'h44332211);
        req_valid[0] = 1'b0;
        tick(); check_eq("rd4_idle", 32'(busy), 32'h0);

        // Fixed priority: port 1 beats port 0, port 0 follows after the turnaround.
        set_req(1'b0, 1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 2'd0, 32'h101, 32'h0);
        tick(); check_eq("fix_first_a", mem_a, 32'h101);
        tick();
        tick(); check_eq("fix_rsp_p1", 32'(rsp_valid), 32'h2);
        check_eq("fix_rdata_p1", rsp_rdata, 32'h22);
        req_valid[1] = 1'b0;
        tick(); check_eq("fix_turnaround_idle", 32'(busy), 32'h0);
        tick(); check_eq("fix_second_a", mem_a, 32'h100);
        tick();
        tick(); check_eq("fix_rsp_p0", 32'(rsp_valid), 32'h1);
        check_eq("fix_rdata_p0", rsp_rdata, 32'h11);
        req_valid[0] = 1'b0;
        tick();

        // Port 1, 2-byte write 0xBEEF at 0x200.
        set_req(1'b1, 1'b1, 1'b1, 2'd1, 32'h200, 32'h0000BEEF);
        tick(); check_eq("wr2_b0", {mem_a[23:0], mem_dout}, {24'h000200, 8'hEF});
        check_eq("wr2_wr0", 32'(mem_wr), 32'h1);
        tick(); check_eq("wr2_b1", {mem_a[23:0], mem_dout}, {24'h000201, 8'hBE});
        check_eq("wr2_wr1", 32'(mem_wr), 32'h1);
        tick(); check_eq("wr2_rsp", 32'(rsp_valid), 32'h2);
        check_eq("wr2_wr_off", 32'(mem_wr), 32'h0);
        req_valid[1] = 1'b0;
        tick(); check_eq("wr2_ram", {16'h0, ram[12'h201], ram[12'h200]}, 32'hBEEF);

        // 1-byte write into the UART region while its buffer is full.
        io_full = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 2'd0, 32'h0003_0000, 32'h41);
        wr_cnt = 0; rsp_cnt = 0;
        for (int c = 0; c < 5; c++) begin tick(); wr_cnt += int'(mem_wr); end
        check_eq("io_hold_no_wr", 32'(wr_cnt), 32'h0);
        io_full = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_wr) begin wr_cnt++; wr_a = mem_a; wr_d = mem_dout; end
            if (rsp_valid != 2'b00) begin rsp_cnt++; rsp_seen = rsp_valid; req_valid[0] = 1'b0; end
        end
        check_eq("io_wr_count", 32'(wr_cnt), 32'h1);
        check_eq("io_wr_a", wr_a, 32'h0003_0000);
        check_eq("io_wr_d", 32'(wr_d), 32'h41);
        check_eq("io_rsp_count", 32'(rsp_cnt), 32'h1);
        check_eq("io_rsp_port", 32'(rsp_seen), 32'h1);

        // Flush of an in-flight 4-byte read.
        set_req(1'b0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        wr_cnt = 0; rsp_cnt = 0;
        tick(); tick();
        req_flush[0] = 1'b1; req_valid[0] = 1'b0;
        tick(); check_eq("flush_busy_t3", 32'(busy), 32'h0);
        req_flush[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            wr_cnt += int'(mem_wr);
            if (rsp_valid != 2'b00) rsp_cnt++;
        end
        check_eq("flush_no_rsp", 32'(rsp_cnt), 32'h0);
        check_eq("flush_no_wr", 32'(wr_cnt), 32'h0);

        // 4-byte read with rdy low in T+3..T+5.
        set_req(1'b0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        wr_cnt = 0; rsp_cnt = 0; rsp_seen = '0;
        tick(); tick();
        tick(); rdy = 1'b0;
        tick(); wr_cnt += int'(mem_wr);
        tick(); wr_cnt += int'(mem_wr);
        tick(); rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            wr_cnt += int'(mem_wr);
            if (rsp_valid != 2'b00) begin
                rsp_cnt++; rsp_seen = rsp_valid; req_valid[0] = 1'b0;
                check_eq("stall_rdata", rsp_rdata, 32'h44332211);
            end
        end
        check_eq("stall_rsp_count", 32'(rsp_cnt), 32'h1);
        check_eq("stall_rsp_port", 32'(rsp_seen), 32'h1);
        check_eq("stall_no_wr", 32'(wr_cnt), 32'h0);

        // Asynchronous reset in the middle of a 4-byte write.
        set_req(1'b1, 1'b1, 1'b1, 2'd2, 32'h200, 32'hDEADBEEF);
        tick(); check_eq("rstw_wr_t1", 32'(mem_wr), 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rstw_mem_wr", 32'(mem_wr), 32'h0);
        check_eq("rstw_mem_a", mem_a, 32'h0);
        check_eq("rstw_mem_dout", 32'(mem_dout), 32'h0);
        check_eq("rstw_busy", 32'(busy), 32'h0);
        check_eq("rstw_rdata", rsp_rdata, 32'h0);
        check_eq("rstw_rsp", 32'(rsp_valid), 32'h0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick(); check_eq("rstw_idle_after", 32'(busy), 32'h0);

        // Round-robin: both ports held with 1-byte writes, grants alternate from port 0.
        rr_req_valid = 2'b11; rr_req_wr = 2'b11; rr_req_size = 4'b0000;
        rr_req_addr  = {32'h20, 32'h10};
        rr_req_wdata = {32'hB2, 32'hA1};
        got = 0; wr_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rr_mem_wr && wr_cnt == 0) begin rr_first_d = rr_mem_dout; wr_cnt++; end
            if (rr_rsp_valid != 2'b00 && got < 4) begin order[got] = rr_rsp_valid; got++; end
        end
        rr_req_valid = 2'b00;
        check_eq("rr_count", 32'(got), 32'h4);
        check_eq("rr_first_data", 32'(rr_first_d), 32'hA1);
        check_eq("rr_grant0", 32'(order[0]), 32'h1);
        check_eq("rr_grant1", 32'(order[1]), 32'h2);
        check_eq("rr_grant2", 32'(order[2]), 32'h1);
        check_eq("rr_grant3", 32'(order[3]), 32'h2);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl_multiport.md
Name: mem_ctrl_multiport

Overview:
- Parametrised successor to the CPU's byte-bus memory controller.
- Arbitrates NUM_PORTS requesters (IF, MEM, future I/D caches) onto the single 8-bit RAM/IO bus: 1-cycle read latency, 1-cycle writes.
- Adds selectable fixed or round-robin arbitration, per-port abort, multi-byte pipelined reads, and UART back-pressure stalls.
- Sits between the pipeline and the cpu top-level mem_* pins.

Parameters:
NUM_PORTS, 2, number of requesters; port NUM_PORTS-1 is highest fixed priority
ARB_MODE, 0, 0 = fixed priority, 1 = round-robin
ADDR_W, 32, address width

Ports:
clk_in  input  1  clock; all state on rising edge
rst_in  input  1  reset: asynchronous, active-low
rdy_in  input  1  pause when low
mem_din  input  8  RAM/IO read byte (valid the cycle after its address)
mem_dout  output  8  write byte
mem_a  output  ADDR_W  byte address
mem_wr  output  1  1 = write
io_buffer_full  input  1  UART TX buffer full
req_valid  input  NUM_PORTS  request per port; held until rsp_valid or flush
req_wr  input  NUM_PORTS  1 = store
req_size  input  2*NUM_PORTS  0 = 1B, 1 = 2B, 2/3 = 4B
req_addr  input  ADDR_W*NUM_PORTS  start address
req_wdata  input  32*NUM_PORTS  store data, little-endian
req_flush  input  NUM_PORTS  abort port's read / mask its request this cycle
rsp_valid  output  NUM_PORTS  one-cycle completion pulse for the owning port
rsp_rdata  output  32  read data, little-endian, unused upper bytes zero
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_in low, any time, mid-transfer included):
  - State IDLE; mem_a=0, mem_dout=0, mem_wr=0, rsp_valid=0, rsp_rdata=0, busy=0.
  - RR pointer=NUM_PORTS-1, so port 0 is favoured first.
- States: IDLE, READ, WRITE, IO_WAIT, DONE. n = byte count from req_size.
- Arbitration (IDLE only, edge T):
  - Eligible ports: req_valid & ~req_flush.
  - ARB_MODE 0: highest eligible index wins.
  - ARB_MODE 1: first eligible index after the RR pointer wins; pointer := winner.
  - Winner's req_* are latched; the live inputs are not used afterwards.
- READ (pipelined):
  - mem_a = addr+i, mem_wr=0 during cycle T+1+i, for i = 0..n-1.
  - Byte i is captured from mem_din at the end of cycle T+2+i into rdata[8i+7:8i].
  - After the last capture go to DONE; rsp_valid[p]=1 in cycle T+n+2.
- WRITE:
  - mem_wr=1, mem_a=addr+i, mem_dout=wdata byte i in cycle T+1+i.
  - DONE in cycle T+n+1.
- IO_WAIT:
  - Entered instead of issuing a write byte when that byte's address has [17:16]==2'b11 and io_buffer_full=1.
  - mem_wr=0 while waiting.
  - The held byte is issued in the first cycle after io_buffer_full is sampled low; then WRITE resumes.
- DONE:
  - rsp_valid[p] high for exactly one cycle; rsp_rdata valid (holds its value until the next read completes).
  - Next edge goes to IDLE. No request is accepted in DONE, which guarantees a one-cycle turnaround so the requester can drop req_valid.
- Flush:
  - req_flush[p] for the owning port in READ: next edge goes to IDLE, mem_wr=0, no rsp_valid, partial rdata discarded.
  - Flush during WRITE/IO_WAIT is ignored; stores always complete.
- rdy_in low:
  - All registers frozen; mem_wr forced 0.
  - In READ, on resume the controller re-issues the address of the lowest uncaptured byte before capturing. This adds ≥1 cycle; data must be correct.
- Address arithmetic: addr+i is modulo 2^ADDR_W; no alignment requirement.
- Simultaneous requests: the loser keeps req_valid and is served after the current DONE.

Test Plan:
- ARB_MODE 0: port0 4B read @0x100, RAM 0x100..0x103 = 11 22 33 44 -> mem_a 0x100..0x103 in T+1..T+4; rsp_valid[0] in T+6; rsp_rdata=0x44332211.
- ARB_MODE 0: ports 0 and 1 request together -> port1 served first, port0 accepted on the edge after DONE. ARB_MODE 1, both held -> grants alternate 0,1,0,1.
- Port1 2B write 0xBEEF @0x200 -> mem_wr=1 with (0x200,EF) then (0x201,BE); rsp_valid[1] in T+3.
- 1B write 0x41 @0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0 for those cycles; single write of 0x41 after release; exactly one rsp_valid.
- 4B read, req_flush[0] in T+2 -> no rsp_valid, busy=0 from T+3, mem_wr never 1.
- 4B read with rdy_in low during T+3..T+5 -> rsp_rdata still correct; no mem_wr. Separately, rst_in low mid-WRITE -> all outputs 0 immediately, IDLE.
